// File: rtl/au_filter_ctrl.sv
// au_filter_ctrl: sequences one filter run per I2S word and buffers the
// results for the DAC.
//   sys_clk, sys_rst       : clock and synchronous active-high reset
//   ws, au_data            : async word select and the sample it frames
//   flt_start, flt_din     : start pulse and sample presented to the filter
//   flt_done, flt_dout     : filter completion pulse and result
//   dac_clka, dac_dat_a    : DAC latch clock and offset-binary code
//   ovf, drop_cnt          : lost-result flag and dropped-sample counter
module au_filter_ctrl #(
    parameter int unsigned DW         = 24,
    parameter int unsigned OW         = 10,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned TIMEOUT    = 255,
    parameter int unsigned DAC_HI     = 4
) (
    input  logic          sys_clk,
    input  logic          sys_rst,
    input  logic          ws,
    input  logic [DW-1:0] au_data,
    output logic          flt_start,
    output logic [DW-1:0] flt_din,
    input  logic          flt_done,
    input  logic [DW-1:0] flt_dout,
    output logic          dac_clka,
    output logic [OW-1:0] dac_dat_a,
    output logic          ovf,
    output logic [7:0]    drop_cnt
);

    localparam int unsigned AW   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNTW = AW + 1;
    localparam int unsigned CW   = $clog2(TIMEOUT + 1);
    localparam int unsigned HW   = $clog2(DAC_HI + 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LATCH,
        ST_START,
        ST_WAIT,
        ST_STORE
    } state_t;

    logic             r_ws_s1, r_ws_s2, r_ws_d;
    logic             w_ws_fall, w_ws_rise;
    state_t           r_state, w_state_nxt;
    logic             w_load, w_capture, w_push, w_timeout, w_drop;
    logic [CW-1:0]    r_wait_cnt;
    logic [OW-1:0]    r_result;
    logic [OW-1:0]    r_mem [FIFO_DEPTH];
    logic [AW-1:0]    r_wr_ptr, r_rd_ptr;
    logic [CNTW-1:0]  r_count;
    logic             w_full, w_pop, w_wr_en;
    logic             r_pop_d;
    logic [HW-1:0]    r_hi_cnt;
    logic             r_flt_start, r_dac_clka, r_ovf;
    logic [DW-1:0]    r_flt_din;
    logic [OW-1:0]    r_dac_dat;
    logic [7:0]       r_drop_cnt;
    logic             w_unused_lsbs;

    assign w_unused_lsbs = ^flt_dout[DW-OW-1:0];

    // ws synchronizer and edge detect
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_ws_s1 <= 1'b0;
            r_ws_s2 <= 1'b0;
            r_ws_d  <= 1'b0;
        end else begin
            r_ws_s1 <= ws;
            r_ws_s2 <= r_ws_s1;
            r_ws_d  <= r_ws_s2;
        end
    end

    assign w_ws_fall = r_ws_d & ~r_ws_s2;
    assign w_ws_rise = ~r_ws_d & r_ws_s2;

    // FSM state register
    always_ff @(posedge sys_clk) begin
        if (sys_rst) r_state <= ST_IDLE;
        else         r_state <= w_state_nxt;
    end

    // FSM next state and per-state strobes
    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_capture   = 1'b0;
        w_push      = 1'b0;
        w_timeout   = 1'b0;
        case (r_state)
            ST_IDLE:  if (w_ws_fall) w_state_nxt = ST_LATCH;
            ST_LATCH: begin
                w_load      = 1'b1;
                w_state_nxt = ST_START;
            end
            ST_START: w_state_nxt = ST_WAIT;
            ST_WAIT: begin
                // flt_done wins over a timeout landing in the same cycle
                if (flt_done) begin
                    w_capture   = 1'b1;
                    w_state_nxt = ST_STORE;
                end else if (r_wait_cnt == CW'(TIMEOUT - 1)) begin
                    w_timeout   = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_STORE: begin
                w_push      = 1'b1;
                w_state_nxt = ST_IDLE;
            end
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    // A timeout and a busy ws_fall together count as one drop
    assign w_drop = w_timeout | (w_ws_fall & (r_state != ST_IDLE));

    // Filter handshake, wait counter, result capture and drop counter
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_flt_start <= 1'b0;
            r_flt_din   <= '0;
            r_wait_cnt  <= '0;
            r_result    <= '0;
            r_drop_cnt  <= 8'd0;
        end else begin
            r_flt_start <= (w_state_nxt == ST_START);
            if (w_load)                   r_flt_din  <= au_data;
            if (r_state == ST_START)      r_wait_cnt <= '0;
            else if (r_state == ST_WAIT)  r_wait_cnt <= r_wait_cnt + CW'(1);
            // flt_dout is only valid with flt_done, so convert it here
            if (w_capture) r_result <= {~flt_dout[DW-1], flt_dout[DW-2:DW-OW]};
            if (w_drop && (r_drop_cnt != 8'hFF)) r_drop_cnt <= r_drop_cnt + 8'd1;
        end
    end

    assign w_full  = (r_count == CNTW'(FIFO_DEPTH));
    assign w_pop   = w_ws_rise & (r_count != '0);
    // A pop frees the slot the same cycle, so a full FIFO still accepts
    assign w_wr_en = w_push & (~w_full | w_pop);

    // Result FIFO storage
    always_ff @(posedge sys_clk) begin
        if (w_wr_en) r_mem[r_wr_ptr] <= r_result;
    end

    // FIFO pointers, occupancy and overflow flag
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_ovf    <= 1'b0;
        end else begin
            if (w_wr_en) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)   r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({w_wr_en, w_pop})
                2'b10:   r_count <= r_count + CNTW'(1);
                2'b01:   r_count <= r_count - CNTW'(1);
                default: r_count <= r_count;
            endcase
            if (w_push && w_full && !w_pop) r_ovf <= 1'b1;
        end
    end

    // DAC word update followed one cycle later by a DAC_HI-long latch pulse
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_dac_dat  <= {1'b1, {(OW-1){1'b0}}};
            r_pop_d    <= 1'b0;
            r_hi_cnt   <= '0;
            r_dac_clka <= 1'b0;
        end else begin
            r_pop_d <= w_pop;
            if (w_pop) r_dac_dat <= r_mem[r_rd_ptr];
            if (r_pop_d) begin
                r_hi_cnt   <= HW'(DAC_HI);
                r_dac_clka <= 1'b1;
            end else begin
                r_dac_clka <= (r_hi_cnt > HW'(1));
                if (r_hi_cnt != '0) r_hi_cnt <= r_hi_cnt - HW'(1);
            end
        end
    end

    assign flt_start = r_flt_start;
    assign flt_din   = r_flt_din;
    assign dac_clka  = r_dac_clka;
    assign dac_dat_a = r_dac_dat;
    assign ovf       = r_ovf;
    assign drop_cnt  = r_drop_cnt;

endmodule

// File: tb/tb_au_filter_ctrl.sv
// Directed bench for au_filter_ctrl: nominal flow, full-scale codes, timeout,
// busy drops with saturation, FIFO overflow ordering and reset during WAIT.
module tb_au_filter_ctrl;

    logic        sys_clk = 1'b0;
    logic        sys_rst;
    logic        ws;
    logic [23:0] au_data;
    logic        flt_start;
    logic [23:0] flt_din;
    logic        flt_done;
    logic [23:0] flt_dout;
    logic        dac_clka;
    logic [9:0]  dac_dat_a;
    logic        ovf;
    logic [7:0]  drop_cnt;

    int n_cmp = 0;
    int n_err = 0;

    au_filter_ctrl dut (
        .sys_clk   (sys_clk),
        .sys_rst   (sys_rst),
        .ws        (ws),
        .au_data   (au_data),
        .flt_start (flt_start),
        .flt_din   (flt_din),
        .flt_done  (flt_done),
        .flt_dout  (flt_dout),
        .dac_clka  (dac_clka),
        .dac_dat_a (dac_dat_a),
        .ovf       (ovf),
        .drop_cnt  (drop_cnt)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge sys_clk);
            #1;
        end
    endtask

    task automatic watch_starts(input int n, output int cnt);
        cnt = 0;
        repeat (n) begin
            tick(1);
            if (flt_start) cnt++;
        end
    endtask

    // ws high -> low, expect flt_start exactly 2 cycles after ws_fall, then
    // answer with flt_done dly cycles after flt_start
    task automatic sample(input logic [23:0] din, input logic [23:0] dout, input int dly);
        au_data = din;
        ws      = 1'b0;
        tick(3);
        check_eq("start_early", 32'(flt_start), 32'd0);
        tick(1);
        check_eq("start", 32'(flt_start), 32'd1);
        check_eq("flt_din", 32'(flt_din), 32'(din));
        tick(1);
        check_eq("start_len", 32'(flt_start), 32'd0);
        tick(dly - 1);
        flt_dout = dout;
        flt_done = 1'b1;
        tick(1);
        flt_done = 1'b0;
        flt_dout = 24'h0;
        tick(3);
    endtask

    // ws low -> high, check the popped word and the dac_clka pulse shape
    task automatic pop_check(input logic [9:0] exp, input logic pulse);
        int highs;
        int first;
        highs = 0;
        first = -1;
        ws    = 1'b1;
        tick(3);
        check_eq("dac_dat", 32'(dac_dat_a), 32'(exp));
        check_eq("clka_pre", 32'(dac_clka), 32'd0);
        for (int i = 1; i <= 8; i++) begin
            tick(1);
            if (dac_clka) begin
                highs++;
                if (first < 0) first = i;
            end
        end
        check_eq("clka_len", 32'(highs), pulse ? 32'd4 : 32'd0);
        if (pulse) check_eq("clka_dly", 32'(first), 32'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no end expected end of run");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        sys_rst  = 1'b1;
        ws       = 1'b1;
        au_data  = 24'h0;
        flt_done = 1'b0;
        flt_dout = 24'h0;
        tick(2);
        check_eq("rst_start", 32'(flt_start), 32'd0);
        check_eq("rst_din", 32'(flt_din), 32'd0);
        check_eq("rst_clka", 32'(dac_clka), 32'd0);
        check_eq("rst_ovf", 32'(ovf), 32'd0);
        check_eq("rst_drop", 32'(drop_cnt), 32'd0);
        check_eq("rst_dac", 32'(dac_dat_a), 32'h200);
        sys_rst = 1'b0;
        tick(4);

        // nominal flow
        sample(24'h7F0000, 24'h400000, 10);
        check_eq("dac_before_rise", 32'(dac_dat_a), 32'h200);
        pop_check(10'h300, 1'b1);

        // full-scale codes
        sample(24'h012345, 24'h800000, 5);
        pop_check(10'h000, 1'b1);
        sample(24'h054321, 24'h7FFFFF, 7);
        pop_check(10'h3FF, 1'b1);

        // timeout: no flt_done, one drop, nothing pushed
        au_data = 24'h111111;
        ws      = 1'b0;
        tick(4);
        check_eq("to_start", 32'(flt_start), 32'd1);
        tick(250);
        check_eq("to_drop_early", 32'(drop_cnt), 32'd0);
        tick(8);
        check_eq("to_drop", 32'(drop_cnt), 32'd1);
        pop_check(10'h3FF, 1'b0);

        // busy drop during WAIT
        ws = 1'b0;
        tick(4);
        check_eq("busy_start", 32'(flt_start), 32'd1);
        tick(5);
        ws = 1'b1;
        tick(3);
        ws = 1'b0;
        watch_starts(12, n);
        check_eq("busy_no_start", 32'(n), 32'd0);
        check_eq("busy_drop", 32'(drop_cnt), 32'd2);
        for (int i = 0; i < 300; i++) begin
            ws = 1'b1;
            tick(3);
            ws = 1'b0;
            tick(3);
        end
        check_eq("drop_sat", 32'(drop_cnt), 32'd255);

        sys_rst = 1'b1;
        ws      = 1'b1;
        tick(2);
        check_eq("drop_clr", 32'(drop_cnt), 32'd0);
        sys_rst = 1'b0;
        tick(4);

        // overflow: five pushes with ws_rise held off
        force dut.w_ws_rise = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            sample(24'(k), 24'(k) << 14, 3);
            if (k == 4) check_eq("ovf_at_4", 32'(ovf), 32'd0);
            ws = 1'b1;
            tick(3);
        end
        check_eq("ovf_at_5", 32'(ovf), 32'd1);
        release dut.w_ws_rise;
        for (int k = 1; k <= 4; k++) begin
            ws = 1'b0;
            tick(3);
            pop_check(10'(32'h200 + k), 1'b1);
        end
        ws = 1'b0;
        tick(3);
        pop_check(10'h204, 1'b0);
        check_eq("ovf_sticky", 32'(ovf), 32'd1);

        // reset during WAIT
        sys_rst = 1'b1;
        tick(2);
        sys_rst = 1'b0;
        tick(4);
        au_data = 24'h123456;
        ws      = 1'b0;
        tick(4);
        check_eq("rw_start", 32'(flt_start), 32'd1);
        tick(5);
        sys_rst = 1'b1;
        tick(1);
        check_eq("rw_dac", 32'(dac_dat_a), 32'h200);
        check_eq("rw_start_rst", 32'(flt_start), 32'd0);
        check_eq("rw_din_rst", 32'(flt_din), 32'd0);
        tick(1);
        sys_rst = 1'b0;
        tick(2);
        flt_dout = 24'h7FFFFF;
        flt_done = 1'b1;
        tick(1);
        flt_done = 1'b0;
        flt_dout = 24'h0;
        watch_starts(20, n);
        check_eq("rw_no_start", 32'(n), 32'd0);
        pop_check(10'h200, 1'b0);
        sample(24'h7F0000, 24'h400000, 10);
        pop_check(10'h300, 1'b1);
        check_eq("rw_drop", 32'(drop_cnt), 32'd0);
        check_eq("rw_ovf", 32'(ovf), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/au_filter_ctrl.md
AU_FILTER_CTRL -- requirements
Module: au_filter_ctrl

Interface
REQ-001 Parameter DW, default 24: audio sample and filter result width, in bits.
REQ-002 Parameter OW, default 10: DAC word width, in bits.
REQ-003 Parameter FIFO_DEPTH, default 4: number of result buffer entries; shall be a power of 2.
REQ-004 Parameter TIMEOUT, default 255: maximum number of sys_clk cycles spent waiting for flt_done.
REQ-005 Parameter DAC_HI, default 4: dac_clka high time, in sys_clk cycles.
REQ-006 Port sys_clk, input, 1 bit: the single clock for the block; all logic is clocked on its rising edge.
REQ-007 Port sys_rst, input, 1 bit: synchronous, active-high reset.
REQ-008 Port ws, input, 1 bit: I2S word select from the PLL; asynchronous to sys_clk.
REQ-009 Port au_data, input, DW bits: signed audio sample; stable around each falling edge of ws.
REQ-010 Port flt_start, output, 1 bit: one-cycle pulse that starts the filter.
REQ-011 Port flt_din, output, DW bits: signed sample presented to the filter.
REQ-012 Port flt_done, input, 1 bit: one-cycle pulse meaning flt_dout is valid.
REQ-013 Port flt_dout, input, DW bits: signed filter result.
REQ-014 Port dac_clka, output, 1 bit: DAC latch clock.
REQ-015 Port dac_dat_a, output, OW bits: DAC code in offset binary.
REQ-016 Port ovf, output, 1 bit: sticky flag, set when a result is lost because the FIFO is full.
REQ-017 Port drop_cnt, output, 8 bits: count of dropped samples; saturates at 255.

Function
REQ-018 ws shall pass through a 2-flop synchronizer; ws_fall and ws_rise are one-cycle pulses generated from the synchronized ws and its one-cycle-delayed copy.
REQ-019 The sequencing FSM shall have the states IDLE, LATCH, START, WAIT and STORE.
REQ-020 In IDLE, ws_fall shall move the FSM to LATCH.
REQ-021 In LATCH, flt_din shall load au_data, and the FSM shall move to START.
REQ-022 In START, flt_start shall be 1 for exactly one cycle, the wait counter shall clear to 0, and the FSM shall move to WAIT.
REQ-023 In WAIT, flt_done shall move the FSM to STORE; if the wait counter reaches TIMEOUT first, the FSM shall return to IDLE and drop_cnt shall increment.
REQ-024 In STORE, the block shall push {~flt_dout[DW-1], flt_dout[DW-2:DW-OW]} into the FIFO and move to IDLE.
REQ-025 A ws_fall that arrives while the FSM is not in IDLE shall be ignored, and drop_cnt shall increment.
REQ-026 flt_done that arrives outside WAIT shall be ignored.
REQ-027 flt_din shall hold its value between loads.
REQ-028 The latency from ws_fall to flt_start shall be exactly 2 cycles.
REQ-029 A push while the FIFO is full shall discard the word and set ovf; ovf shall stay set until reset.
REQ-030 On ws_rise with the FIFO not empty, the block shall pop one word; dac_dat_a shall take that word on the next cycle.
REQ-031 After each update of dac_dat_a, dac_clka shall go high one cycle later and stay high for DAC_HI cycles.
REQ-032 On ws_rise with the FIFO empty, dac_dat_a shall hold its value and no dac_clka pulse shall occur.
REQ-033 A push and a pop in the same cycle shall both take effect and leave the FIFO count unchanged, including when the FIFO is full; ovf shall not be set in that case.
REQ-034 The FIFO read and write pointers shall wrap modulo FIFO_DEPTH.
REQ-035 drop_cnt shall saturate at 255 and never wrap.
REQ-036 A timeout and a ws_fall in the same cycle shall increment drop_cnt by 1 only.

Reset
REQ-037 When sys_rst is high at a rising edge of sys_clk, the FSM shall go to IDLE, the FIFO shall empty, and the synchronizer and wait counter shall clear.
REQ-038 During reset, flt_start, flt_din, dac_clka, ovf and drop_cnt shall be 0, and dac_dat_a shall be 10'h200 (mid-scale).
REQ-039 Reset asserted in the middle of any operation shall abort it, and no further flt_start shall be issued until the next ws_fall after reset is released.

Verification
REQ-040 The bench shall cover nominal flow: au_data=24'h7F0000, with flt_done 10 cycles after flt_start and flt_dout=24'h400000 -> flt_start 2 cycles after ws_fall, flt_din=24'h7F0000, then on the next ws_rise dac_dat_a=10'h300 and a 4-cycle dac_clka pulse.
REQ-041 The bench shall cover negative full scale: flt_dout=24'h800000 -> dac_dat_a=10'h000; flt_dout=24'h7FFFFF -> dac_dat_a=10'h3FF.
REQ-042 The bench shall cover timeout: flt_done never asserted -> return to IDLE 255 cycles after flt_start, drop_cnt=1, no FIFO push.
REQ-043 The bench shall cover overflow: 5 results pushed with no ws_rise -> ovf=1, and the FIFO holds the first 4 words, which pop out in order.
REQ-044 The bench shall cover busy drop: a ws_fall during WAIT -> drop_cnt increments and no second flt_start occurs; 300 such drops -> drop_cnt=255.
REQ-045 The bench shall cover reset during WAIT: FSM returns to IDLE, dac_dat_a=10'h200, a late flt_done is ignored, and a new ws_fall restarts nominal flow.
